inv_mixcol: RTL



---
 rtl/inv_mixcol.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/inv_mixcol.sv
// inv_mixcol: AES-128 inverse MixColumns stage.
// Reads the 128-bit state from SRAM address STATE_ADDR. Applies the GF(2^8)
// inverse MixColumns matrix to each column. Writes the result back to the
// same address. The round controller sequences it through an
// enable/finished handshake.
//
// Optional build macro:
//   INV_MIXCOL_SINGLECYCLE_EN - all four columns in one COL cycle, no counter.
//
// Ports:
//   clk                  system clock, rising edge
//   n_rst                asynchronous active-low reset
//   inv_mixcol_enable    start request, sampled in IDLE only
//   sramReadValue        SRAM read data (row-major), valid during WAIT
//   sramWriteValue       result word (row-major), holds between operations
//   inv_mixcol_finished  one-cycle done pulse
//   sramRead/sramWrite   SRAM strobes
//   sramAddr             SRAM address, 0 outside address phases
//   sramDump/sramInit/sramDumpNum/sramInitNum  tied 0
module inv_mixcol #(
  parameter logic [15:0] STATE_ADDR = 16'd32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inv_mixcol_enable,
  input  logic [127:0] sramReadValue,
  output logic [127:0] sramWriteValue,
  output logic         inv_mixcol_finished,
  output logic         sramRead,
  output logic         sramWrite,
  output logic         sramDump,
  output logic         sramInit,
  output logic [15:0]  sramAddr,
  output logic [2:0]   sramDumpNum,
  output logic [2:0]   sramInitNum
);

  localparam int unsigned NCOL = 4;
  localparam int unsigned NBYTE = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETADDR = 3'd1,
    READ    = 3'd2,
    WAIT    = 3'd3,
    COL     = 3'd4,
    WADDR   = 3'd5,
    WRITE   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t state, next_state;

  // Column-major copies: column c holds {s(0,c), s(1,c), s(2,c), s(3,c)}.
  logic [NCOL-1:0][31:0] in_col;
  logic [NCOL-1:0][31:0] res_col;

  logic        read_nxt;
  logic        write_nxt;
  logic        fin_nxt;
  logic [15:0] addr_nxt;

`ifndef INV_MIXCOL_SINGLECYCLE_EN
  logic [1:0] col_cnt;
`endif

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns on one column {a0,a1,a2,a3}.
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [3:0][7:0] x1, x2, x4, x8, m9, mb, md, me;
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[8*(3-i) +: 8];
      x2[i] = xt(x1[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ x1[i];
      mb[i] = x8[i] ^ x2[i] ^ x1[i];
      md[i] = x8[i] ^ x4[i] ^ x1[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, and the Moore outputs decoded from the state being entered.
  always_comb begin
    next_state = state;
    read_nxt   = 1'b0;
    write_nxt  = 1'b0;
    fin_nxt    = 1'b0;
    addr_nxt   = 16'd0;

    case (state)
      IDLE:    if (inv_mixcol_enable) next_state = SETADDR;
      SETADDR: next_state = READ;
      READ:    next_state = WAIT;
      WAIT:    next_state = COL;
`ifdef INV_MIXCOL_SINGLECYCLE_EN
      COL:     next_state = WADDR;
`else
      COL:     if (col_cnt == 2'd3) next_state = WADDR;
`endif
      WADDR:   next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    case (next_state)
      SETADDR, WADDR: addr_nxt = STATE_ADDR;
      READ: begin
        addr_nxt = STATE_ADDR;
        read_nxt = 1'b1;
      end
      WRITE: begin
        addr_nxt  = STATE_ADDR;
        write_nxt = 1'b1;
      end
      DONE:    fin_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered strobes/address; registering the entered state's decode keeps
  // them aligned with the state itself.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sramRead            <= 1'b0;
      sramWrite           <= 1'b0;
      sramAddr            <= 16'd0;
      inv_mixcol_finished <= 1'b0;
    end else begin
      sramRead            <= read_nxt;
      sramWrite           <= write_nxt;
      sramAddr            <= addr_nxt;
      inv_mixcol_finished <= fin_nxt;
    end
  end

  // Capture the read word, transposing row-major bytes into columns.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_col <= '0;
    end else if (state == WAIT) begin
      for (int c = 0; c < NCOL; c++) begin
        in_col[c] <= {sramReadValue[8*(NBYTE-1-c)      +: 8],
                      sramReadValue[8*(NBYTE-1-(4+c))  +: 8],
                      sramReadValue[8*(NBYTE-1-(8+c))  +: 8],
                      sramReadValue[8*(NBYTE-1-(12+c)) +: 8]};
      end
    end
  end

`ifdef INV_MIXCOL_SINGLECYCLE_EN
  // All columns in the single COL cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      res_col <= '0;
    end else if (state == COL) begin
      for (int c = 0; c < NCOL; c++) begin
        res_col[c] <= inv_col(in_col[c]);
      end
    end
  end
`else
  // One column per COL cycle; the counter wraps back to 0 after column 3.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_cnt <= 2'd0;
      res_col <= '0;
    end else if (state == COL) begin
      col_cnt          <= col_cnt + 2'd1;
      res_col[col_cnt] <= inv_col(in_col[col_cnt]);
    end
  end
`endif

  // Transpose the result columns back to the row-major SRAM layout.
  always_comb begin
    sramWriteValue = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        sramWriteValue[8*(NBYTE-1-(4*r+c)) +: 8] = res_col[c][8*(3-r) +: 8];
      end
    end
  end

  assign sramDump    = 1'b0;
  assign sramInit    = 1'b0;
  assign sramDumpNum = 3'd0;
  assign sramInitNum = 3'd0;

endmodule
